// File: rtl/mura_pkg.sv
// Shared types for the Moore-automaton stimulus driver: automaton state codes,
// one-hot a-vector constants, driver FSM codes and the expected-output function.
package mura_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } mura_state_e;

    typedef enum logic [2:0] {
        DRV_IDLE = 3'd0,
        DRV_RUN  = 3'd1,
        DRV_WAIT = 3'd2,
        DRV_DONE = 3'd3,
        DRV_ERR  = 3'd4
    } drv_state_e;

    // a-vector bit i drives automaton input a<i>
    localparam logic [3:0] A_NONE = 4'b0000;
    localparam logic [3:0] A0     = 4'b0001;
    localparam logic [3:0] A1     = 4'b0010;
    localparam logic [3:0] A2     = 4'b0100;
    localparam logic [3:0] A3     = 4'b1000;

    localparam int MAX_STEPS_DEF = 4;
    localparam int STEP_W_DEF    = 3;

    typedef struct packed {
        drv_state_e  state;
        mura_state_e shadow;
        logic        y_mismatch;
    } drv_dbg_t;

    // Returns {y1, y0} that the automaton shows in state s
    function automatic logic [1:0] expected_y(input mura_state_e s);
        logic [1:0] y;
        case (s)
            S0, S3:  y = 2'b01;
            default: y = 2'b10;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/mura_shadow.sv
// Cycle-exact copy of the 4-state Moore automaton, advanced every edge by the
// registered a-vector so the driver knows the state y1 alone cannot reveal.
module mura_shadow
    import mura_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  a_vec,
    output mura_state_e state
);

    mura_state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S0: begin
                if (a_vec[2]) begin
                    state_d = S1;
                end else if (a_vec[3]) begin
                    state_d = S2;
                end
            end
            S1: begin
                if (a_vec[0]) begin
                    state_d = S2;
                end else if (a_vec[1]) begin
                    state_d = S0;
                end
            end
            S2:      state_d = S1;
            default: state_d = S2;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/mura_driver.sv
// Walks the Moore automaton to a requested state with one-hot a-vector steps.
// Define MURA_DRV_CHECK_EN to cross-check the automaton's y0/y1 against the shadow state.
module mura_driver
    import mura_pkg::*;
#(
    parameter int MAX_STEPS = MAX_STEPS_DEF,
    parameter int STEP_W    = STEP_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] target,
    input  logic       y0,
    input  logic       y1,
    output logic       a0,
    output logic       a1,
    output logic       a2,
    output logic       a3,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       err,
    output drv_dbg_t   dbg
);

    drv_state_e        state_q, state_d;
    mura_state_e       tgt_q, tgt_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic [3:0]        a_q, a_d;
    logic              nack_q, nack_d;

    mura_state_e       shadow;
    logic [3:0]        plan_vec;
    logic              y_mismatch;
    logic              budget_spent;

    mura_shadow u_shadow (
        .clk   (clk),
        .rst_n (rst_n),
        .a_vec (a_q),
        .state (shadow)
    );

    assign y_mismatch   = ({y1, y0} != expected_y(shadow));
    assign budget_spent = (cnt_q == STEP_W'(MAX_STEPS));

    // From S2 no input helps: the automaton falls to S1 by itself, so just wait
    always_comb begin
        plan_vec = A_NONE;
        case (shadow)
            S0: begin
                if (tgt_q == S1) begin
                    plan_vec = A2;
                end else if (tgt_q == S2) begin
                    plan_vec = A3;
                end
            end
            S1: begin
                if (tgt_q == S0) begin
                    plan_vec = A1;
                end else if (tgt_q == S2) begin
                    plan_vec = A0;
                end
            end
            default: plan_vec = A_NONE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        a_d     = A_NONE;
        nack_d  = 1'b0;
        case (state_q)
            DRV_IDLE: begin
                if (start) begin
                    if (target == 2'd3) begin
                        nack_d = 1'b1;
                    end else begin
                        tgt_d   = mura_state_e'(target);
                        cnt_d   = '0;
                        state_d = DRV_RUN;
                    end
                end
            end
            DRV_RUN: begin
                if (shadow == tgt_q) begin
                    state_d = DRV_DONE;
                end else if (budget_spent) begin
                    state_d = DRV_ERR;
                end else begin
                    a_d     = plan_vec;
                    cnt_d   = cnt_q + STEP_W'(1);
                    state_d = DRV_WAIT;
                end
            end
            DRV_WAIT: state_d = DRV_RUN;
            DRV_DONE: state_d = DRV_IDLE;
            DRV_ERR:  state_d = DRV_ERR;
            default:  state_d = DRV_IDLE;
        endcase
`ifdef MURA_DRV_CHECK_EN
        // A y mismatch overrides whatever the FSM planned on this same edge
        if (state_q != DRV_ERR && y_mismatch) begin
            state_d = DRV_ERR;
            a_d     = A_NONE;
            nack_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DRV_IDLE;
            tgt_q   <= S0;
            cnt_q   <= '0;
            a_q     <= A_NONE;
            nack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            nack_q  <= nack_d;
        end
    end

    assign a0   = a_q[0];
    assign a1   = a_q[1];
    assign a2   = a_q[2];
    assign a3   = a_q[3];
    assign busy = (state_q == DRV_RUN) || (state_q == DRV_WAIT);
    assign done = (state_q == DRV_DONE);
    assign nack = nack_q;
    assign err  = (state_q == DRV_ERR);

    assign dbg = '{state: state_q, shadow: shadow, y_mismatch: y_mismatch};

endmodule

// File: tb/tb_mura_driver.sv
// Directed bench for mura_driver with an independent behavioural automaton supplying y0/y1.
module tb_mura_driver;
  import mura_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] target = 2'd0;
  logic       y0, y1;
  logic       a0, a1, a2, a3;
  logic       busy, done, nack, err;
  drv_dbg_t   dbg;
  logic [3:0] a_bus;

  logic       y_force_en = 1'b0;
  logic [1:0] y_force = 2'b00;
  logic [1:0] m_state;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mura_driver dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .target (target),
    .y0     (y0),
    .y1     (y1),
    .a0     (a0),
    .a1     (a1),
    .a2     (a2),
    .a3     (a3),
    .busy   (busy),
    .done   (done),
    .nack   (nack),
    .err    (err),
    .dbg    (dbg)
  );

  assign a_bus = {a3, a2, a1, a0};

  // reference automaton, written from its transition rules
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_state <= 2'd0;
    else begin
      case (m_state)
        2'd0: if (a2) m_state <= 2'd1; else if (a3) m_state <= 2'd2;
        2'd1: if (a0) m_state <= 2'd2; else if (a1) m_state <= 2'd0;
        2'd2: m_state <= 2'd1;
        default: m_state <= 2'd2;
      endcase
    end
  end

  assign y0 = y_force_en ? y_force[0] : (m_state == 2'd0 || m_state == 2'd3);
  assign y1 = y_force_en ? y_force[1] : (m_state == 2'd1 || m_state == 2'd2);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({a_bus, busy, done, nack, err} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000000", {a_bus, busy, done, nack, err});
    end
    n_checks++;
    if (dbg.state !== DRV_IDLE || dbg.shadow !== S0) begin
      n_fail++;
      $display("FAIL reset_state: got fsm=%0d shadow=%0d expected fsm=0 shadow=0", dbg.state, dbg.shadow);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({a_bus, busy, done, nack, err} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected 00000000", {a_bus, busy, done, nack, err});
    end
  endtask

  // S0 -> S2 with a single a3 step
  task automatic test_walk_to_s2();
    logic [3:0]  exp_a [5] = '{4'h0, 4'h8, 4'h0, 4'h0, 4'h0};
    logic        exp_d [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        exp_b [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    mura_state_e exp_s [5] = '{S0, S0, S2, S1, S1};
    start = 1'b1;
    target = 2'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (a_bus !== exp_a[i] || done !== exp_d[i] || busy !== exp_b[i] || dbg.shadow !== exp_s[i]) begin
        n_fail++;
        $display("FAIL walk_s2 cycle %0d: got a=%h done=%b busy=%b shadow=%0d expected a=%h done=%b busy=%b shadow=%0d",
                 i + 1, a_bus, done, busy, dbg.shadow, exp_a[i], exp_d[i], exp_b[i], exp_s[i]);
      end
      if (i < 4) tick();
    end
    n_checks++;
    if (y1 !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL walk_s2_after: got y1=%b err=%b expected y1=1 err=0", y1, err);
    end
  endtask

  // starts in the cycle done has just dropped; only a1 may ever be driven
  task automatic test_back_to_s0();
    logic [3:0]  exp_a [5] = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h0};
    logic        exp_d [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    mura_state_e exp_s [5] = '{S1, S1, S0, S0, S0};
    logic [3:0]  a_seen = 4'h0;
    start = 1'b1;
    target = 2'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_seen = a_seen | a_bus;
      n_checks++;
      if (a_bus !== exp_a[i] || done !== exp_d[i] || dbg.shadow !== exp_s[i]) begin
        n_fail++;
        $display("FAIL to_s0 cycle %0d: got a=%h done=%b shadow=%0d expected a=%h done=%b shadow=%0d",
                 i + 1, a_bus, done, dbg.shadow, exp_a[i], exp_d[i], exp_s[i]);
      end
      if (i < 4) tick();
    end
    n_checks++;
    if (a_seen !== 4'h2 || y0 !== 1'b1) begin
      n_fail++;
      $display("FAIL to_s0_summary: got a_seen=%h y0=%b expected a_seen=2 y0=1", a_seen, y0);
    end
  endtask

  task automatic test_zero_step();
    logic exp_d [3] = '{1'b0, 1'b1, 1'b0};
    logic exp_b [3] = '{1'b1, 1'b0, 1'b0};
    start = 1'b1;
    target = 2'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (a_bus !== 4'h0 || done !== exp_d[i] || busy !== exp_b[i]) begin
        n_fail++;
        $display("FAIL zero_step cycle %0d: got a=%h done=%b busy=%b expected a=0 done=%b busy=%b",
                 i + 1, a_bus, done, busy, exp_d[i], exp_b[i]);
      end
      if (i < 2) tick();
    end
  endtask

  task automatic test_nack();
    start = 1'b1;
    target = 2'd3;
    tick();
    start = 1'b0;
    n_checks++;
    if (nack !== 1'b1 || {a_bus, busy, done} !== 6'h00 || dbg.state !== DRV_IDLE) begin
      n_fail++;
      $display("FAIL nack_pulse: got nack=%b a=%h busy=%b done=%b fsm=%0d expected nack=1 a=0 busy=0 done=0 fsm=0",
               nack, a_bus, busy, done, dbg.state);
    end
    tick();
    n_checks++;
    if (nack !== 1'b0 || {a_bus, busy, done} !== 6'h00 || dbg.state !== DRV_IDLE) begin
      n_fail++;
      $display("FAIL nack_end: got nack=%b a=%h busy=%b done=%b fsm=%0d expected all 0",
               nack, a_bus, busy, done, dbg.state);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0]  exp_a [4] = '{4'h0, 4'h4, 4'h0, 4'h0};
    logic        exp_d [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    mura_state_e exp_s [4] = '{S0, S0, S1, S1};
    start = 1'b1;
    target = 2'd1;
    tick();
    start = 1'b0;
    tick();
    n_checks++;
    if (a_bus !== 4'h4 || dbg.state !== DRV_WAIT) begin
      n_fail++;
      $display("FAIL mid_wait: got a=%h fsm=%0d expected a=4 fsm=2", a_bus, dbg.state);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_bus, busy, done, err} !== 7'h00 || dbg.state !== DRV_IDLE || dbg.shadow !== S0) begin
      n_fail++;
      $display("FAIL mid_reset: got a=%h busy=%b done=%b err=%b fsm=%0d shadow=%0d expected all 0",
               a_bus, busy, done, err, dbg.state, dbg.shadow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    target = 2'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (a_bus !== exp_a[i] || done !== exp_d[i] || dbg.shadow !== exp_s[i]) begin
        n_fail++;
        $display("FAIL mid_rerun cycle %0d: got a=%h done=%b shadow=%0d expected a=%h done=%b shadow=%0d",
                 i + 1, a_bus, done, dbg.shadow, exp_a[i], exp_d[i], exp_s[i]);
      end
      tick();
    end
  endtask

  // S1 -> S2 then S1 -> S0 with no idle gap; a start issued mid-request is dropped
  task automatic test_back_to_back();
    logic [3:0]  exp_a [4] = '{4'h0, 4'h1, 4'h0, 4'h0};
    mura_state_e exp_s [4] = '{S1, S1, S2, S1};
    start = 1'b1;
    target = 2'd2;
    tick();
    target = 2'd3;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) start = 1'b0;
      n_checks++;
      if (a_bus !== exp_a[i] || done !== (i == 3) || nack !== 1'b0 || dbg.shadow !== exp_s[i]) begin
        n_fail++;
        $display("FAIL b2b_s2 cycle %0d: got a=%h done=%b nack=%b shadow=%0d expected a=%h done=%b nack=0 shadow=%0d",
                 i + 1, a_bus, done, nack, dbg.shadow, exp_a[i], (i == 3), exp_s[i]);
      end
      if (i < 3) tick();
    end
    tick();
    start = 1'b1;
    target = 2'd0;
    tick();
    start = 1'b0;
    tick();
    n_checks++;
    if (a_bus !== 4'h2) begin
      n_fail++;
      $display("FAIL b2b_s0_step: got a=%h expected a=2", a_bus);
    end
    tick();
    tick();
    n_checks++;
    if (done !== 1'b1 || dbg.shadow !== S0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_s0_done: got done=%b shadow=%0d err=%b expected done=1 shadow=0 err=0",
               done, dbg.shadow, err);
    end
    tick();
  endtask

`ifdef MURA_DRV_CHECK_EN
  task automatic test_y_check();
    y_force_en = 1'b1;
    y_force = 2'b10;
    tick();
    y_force_en = 1'b0;
    n_checks++;
    if (err !== 1'b1 || a_bus !== 4'h0 || busy !== 1'b0 || dbg.state !== DRV_ERR) begin
      n_fail++;
      $display("FAIL ycheck_trip: got err=%b a=%h busy=%b fsm=%0d expected err=1 a=0 busy=0 fsm=4",
               err, a_bus, busy, dbg.state);
    end
    start = 1'b1;
    target = 2'd1;
    tick();
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (err !== 1'b1 || {a_bus, busy, done, nack} !== 7'h00) begin
        n_fail++;
        $display("FAIL ycheck_sticky cycle %0d: got err=%b a=%h busy=%b done=%b nack=%b expected err=1 rest 0",
                 i, err, a_bus, busy, done, nack);
      end
      tick();
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL ycheck_clear: got err=%b expected 0", err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask
`else
  task automatic test_y_check();
    y_force_en = 1'b1;
    y_force = 2'b10;
    start = 1'b1;
    target = 2'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (err !== 1'b0 || done !== (i == 3)) begin
        n_fail++;
        $display("FAIL yignore cycle %0d: got err=%b done=%b expected err=0 done=%b", i + 1, err, done, (i == 3));
      end
      tick();
    end
    y_force_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_walk_to_s2();
    test_back_to_s0();
    test_zero_step();
    test_nack();
    test_reset_mid();
    test_back_to_back();
    test_y_check();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
